// File: rtl/qspi_flash_pkg.sv
`default_nettype none
//==============================================================================
// Module : qspi_flash_pkg
// Brief  : Shared types and constants for the internal-flash QSPI arbiter.
// Rev    : 1.0 - initial release
//==============================================================================
package qspi_flash_pkg;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int         CMD_BITS     = 8;
  localparam int         ADDR_BITS    = 24;
  localparam int         ADDR_BYTES   = ADDR_BITS / CMD_BITS;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_GAP = 3'd1,
    ST_CMD      = 3'd2,
    ST_ADDR     = 3'd3,
    ST_DATA     = 3'd4,
    ST_CS_END   = 3'd5,
    ST_RELEASE  = 3'd6
  } arb_state_t;

  typedef enum logic {
    OWN_MCU = 1'b0,
    OWN_FAB = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/qspi_flash_arb_shifter.sv
`default_nettype none
//==============================================================================
// Module : spi_bit_shifter
// Brief  : Single-bit SPI engine. Two clk25 cycles per bit (phase 0 sclk low,
//          phase 1 sclk high); one shared register shifts TX out of the MSB
//          and RX into the LSB on the edge that ends phase 1.
// Rev    : 1.0 - initial release
//==============================================================================
module spi_bit_shifter
  import qspi_flash_pkg::*;
(
  input  logic       clk25,
  input  logic       fpga_rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  localparam logic [2:0] c_last_bit = 3'(CMD_BITS - 1);

  logic       r_act;
  logic       r_ph;
  logic [7:0] r_sr;
  logic [2:0] r_bit;

  // A byte ends on the phase-1 cycle of its eighth bit; the caller may reload
  // on that same edge so consecutive bytes stream without a gap.
  assign byte_done = r_act & r_ph & (r_bit == c_last_bit);
  assign rx_byte   = {r_sr[6:0], miso};
  assign sclk      = r_ph;
  assign mosi      = r_sr[7];

  // Phase toggle, shift and bit counting; a reload has priority over shifting.
  always_ff @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      r_act <= 1'b0;
      r_ph  <= 1'b0;
      r_sr  <= 8'h00;
      r_bit <= 3'd0;
    end else if (load) begin
      r_act <= 1'b1;
      r_ph  <= 1'b0;
      r_sr  <= load_data;
      r_bit <= 3'd0;
    end else if (r_act) begin
      if (!r_ph) begin
        r_ph <= 1'b1;
      end else begin
        r_ph  <= 1'b0;
        r_sr  <= {r_sr[6:0], miso};
        r_bit <= r_bit + 3'd1;
        if (r_bit == c_last_bit) begin
          r_act <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/qspi_flash_arb.sv
`default_nettype none
//==============================================================================
// Module : qspi_flash_arb
// Brief  : Internal-flash QSPI pin arbiter. Passes the MCU master through and,
//          on a fabric request, waits for MCU idle, takes the pins and runs a
//          single-bit SPI READ (0x03) of 1..256 bytes before handing back.
// Rev    : 1.0 - initial release
//==============================================================================
module qspi_flash_arb
  import qspi_flash_pkg::*;
#(
  parameter int IDLE_GAP = 4,
  parameter int CS_HIGH  = 2
) (
  input  logic        clk25,
  input  logic        fpga_rst_n,
  input  logic        rd_req,
  input  logic [23:0] rd_addr,
  input  logic [7:0]  rd_len,
  output logic        rd_busy,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_done,
  output logic        mcu_collide,
  input  logic        mcu_sclk,
  input  logic        mcu_ss,
  input  logic [3:0]  mcu_txd,
  input  logic [3:0]  mcu_oen,
  output logic [3:0]  mcu_rxd,
  output logic        fl_cclk,
  output logic        fl_cs_n,
  output logic [3:0]  fl_txd,
  output logic [3:0]  fl_oen,
  input  logic [3:0]  fl_rxd
);

  localparam logic [3:0] c_gap_last  = 4'(IDLE_GAP - 1);
  localparam logic [3:0] c_cs_last   = 4'(CS_HIGH - 1);
  localparam logic [1:0] c_addr_last = 2'(ADDR_BYTES - 1);

  arb_state_t  r_state, w_state_nxt;
  owner_t      r_own, w_own_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_done, w_done_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_collide;
  logic        r_cs_n, w_cs_n_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_len, w_len_nxt;
  logic [23:0] r_addr, w_addr_nxt;
  logic [1:0]  r_fld, w_fld_nxt;

  logic        w_load;
  logic [7:0]  w_load_data;
  logic        w_sh_sclk;
  logic        w_sh_mosi;
  logic        w_sh_done;
  logic [7:0]  w_sh_rx;
  logic        w_fab_mosi;

  spi_bit_shifter u_shifter (
    .clk25      (clk25),
    .fpga_rst_n (fpga_rst_n),
    .load       (w_load),
    .load_data  (w_load_data),
    .miso       (fl_rxd[1]),
    .sclk       (w_sh_sclk),
    .mosi       (w_sh_mosi),
    .byte_done  (w_sh_done),
    .rx_byte    (w_sh_rx)
  );

  assign rd_busy     = r_busy;
  assign rd_data     = r_data;
  assign rd_valid    = r_valid;
  assign rd_done     = r_done;
  assign mcu_collide = r_collide;

  // The shifter is reloaded with zero for each data byte, so MOSI already
  // idles low there; the explicit gate keeps IO0 quiet regardless.
  assign w_fab_mosi = (r_state == ST_DATA) ? 1'b0 : w_sh_mosi;

  // FSM state register.
  always_ff @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decisions; shifter loads are issued on the same
  // edge a field byte completes so the SPI clock never pauses mid-transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_own_nxt   = r_own;
    w_busy_nxt  = r_busy;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_data_nxt  = r_data;
    w_cs_n_nxt  = r_cs_n;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_addr_nxt  = r_addr;
    w_fld_nxt   = r_fld;
    w_load      = 1'b0;
    w_load_data = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (rd_req) begin
          w_addr_nxt  = rd_addr;
          w_len_nxt   = rd_len;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_WAIT_GAP;
        end
      end
      ST_WAIT_GAP: begin
        // r_cnt holds consecutive idle cycles already seen; this cycle makes
        // IDLE_GAP when it is idle too.
        if (!mcu_ss) begin
          w_cnt_nxt = 4'd0;
        end else if (r_cnt == c_gap_last) begin
          w_own_nxt   = OWN_FAB;
          w_cs_n_nxt  = 1'b0;
          w_cnt_nxt   = 4'd0;
          w_load      = 1'b1;
          w_load_data = SPI_CMD_READ;
          w_state_nxt = ST_CMD;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_CMD: begin
        if (w_sh_done) begin
          w_load      = 1'b1;
          w_load_data = r_addr[ADDR_BITS-1 -: CMD_BITS];
          w_addr_nxt  = r_addr << CMD_BITS;
          w_fld_nxt   = 2'd0;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (w_sh_done) begin
          w_load = 1'b1;
          if (r_fld == c_addr_last) begin
            w_load_data = 8'h00;
            w_state_nxt = ST_DATA;
          end else begin
            w_load_data = r_addr[ADDR_BITS-1 -: CMD_BITS];
            w_addr_nxt  = r_addr << CMD_BITS;
            w_fld_nxt   = r_fld + 2'd1;
          end
        end
      end
      ST_DATA: begin
        if (w_sh_done) begin
          w_data_nxt  = w_sh_rx;
          w_valid_nxt = 1'b1;
          if (r_len == 8'd0) begin
            w_cs_n_nxt  = 1'b1;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_CS_END;
          end else begin
            w_len_nxt   = r_len - 8'd1;
            w_load      = 1'b1;
            w_load_data = 8'h00;
          end
        end
      end
      ST_CS_END: begin
        if (r_cnt == c_cs_last) begin
          w_state_nxt = ST_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_RELEASE: begin
        w_own_nxt   = OWN_MCU;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and status registers; collision flag is sticky until reset.
  always_ff @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      r_own     <= OWN_MCU;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_data    <= 8'h00;
      r_collide <= 1'b0;
      r_cs_n    <= 1'b1;
      r_cnt     <= 4'd0;
      r_len     <= 8'd0;
      r_addr    <= 24'd0;
      r_fld     <= 2'd0;
    end else begin
      r_own   <= w_own_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_data  <= w_data_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_addr  <= w_addr_nxt;
      r_fld   <= w_fld_nxt;
      if ((r_own == OWN_FAB) && !mcu_ss) begin
        r_collide <= 1'b1;
      end
    end
  end

  // Pin ownership mux; output enables follow chip select so the data pins
  // are only driven while the flash is selected.
  always_comb begin
    if (r_own == OWN_FAB) begin
      fl_cclk = w_sh_sclk;
      fl_cs_n = r_cs_n;
      fl_txd  = {2'b11, 1'b0, w_fab_mosi};
      fl_oen  = r_cs_n ? 4'hF : 4'hE;
      mcu_rxd = 4'hF;
    end else begin
      fl_cclk = mcu_sclk;
      fl_cs_n = mcu_ss;
      fl_txd  = mcu_txd;
      fl_oen  = mcu_oen;
      mcu_rxd = fl_rxd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qspi_flash_arb.sv
`default_nettype none
//==============================================================================
// Module : tb_qspi_flash_arb
// Brief  : Self-checking bench: timeline model of the expected transaction,
//          behavioural SPI flash, per-cycle compare and directed checks.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_qspi_flash_arb;

  localparam int IDLE_GAP = 4;
  localparam int CS_HIGH  = 2;

  logic        clk25 = 1'b0;
  logic        fpga_rst_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [23:0] rd_addr = '0;
  logic [7:0]  rd_len = '0;
  logic        rd_busy, rd_valid, rd_done, mcu_collide;
  logic [7:0]  rd_data;
  logic        mcu_sclk = 1'b0, mcu_ss = 1'b1;
  logic [3:0]  mcu_txd = '0, mcu_oen = 4'hF;
  logic [3:0]  mcu_rxd;
  logic        fl_cclk, fl_cs_n;
  logic [3:0]  fl_txd, fl_oen, fl_rxd;

  logic        pass_mode = 1'b0;
  logic [3:0]  tb_rxd_pass = '0;
  logic        flash_miso = 1'b1;
  assign fl_rxd = pass_mode ? tb_rxd_pass : {2'b11, flash_miso, 1'b1};

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  qspi_flash_arb #(.IDLE_GAP(IDLE_GAP), .CS_HIGH(CS_HIGH)) dut (
    .clk25(clk25), .fpga_rst_n(fpga_rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
    .mcu_collide(mcu_collide),
    .mcu_sclk(mcu_sclk), .mcu_ss(mcu_ss), .mcu_txd(mcu_txd), .mcu_oen(mcu_oen),
    .mcu_rxd(mcu_rxd),
    .fl_cclk(fl_cclk), .fl_cs_n(fl_cs_n), .fl_txd(fl_txd), .fl_oen(fl_oen),
    .fl_rxd(fl_rxd)
  );

  always #20 clk25 = ~clk25;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural SPI flash ----------------
  logic [7:0]  flash_bytes [256];
  logic [31:0] cap = '0;
  int          fb_cnt = 0;

  always @(posedge fl_cclk or posedge fl_cs_n or negedge fpga_rst_n) begin
    if (fl_cs_n || !fpga_rst_n) begin
      fb_cnt = 0;
    end else begin
      if (fb_cnt < 32) begin
        cap = {cap[30:0], fl_txd[0]};
      end else begin
        int j;
        int b;
        logic [7:0] byt;
        j   = ((fb_cnt - 32) / 8) % 256;
        b   = (fb_cnt - 32) % 8;
        byt = flash_bytes[j];
        flash_miso = byt[7-b];
      end
      fb_cnt++;
    end
  end

  // ---------------- transaction timeline model ----------------
  // m_t counts cycles since the fabric took the pins: bytes land at
  // 80+16j, chip select rises with the last byte, done follows CS_HIGH+1 later.
  int          m_mode = 0;
  int          m_run = 0;
  int          m_t = 0;
  int          m_len = 0;
  logic [31:0] m_seq = '0;
  logic        e_busy = 1'b0, e_valid = 1'b0, e_done = 1'b0;
  logic        e_own = 1'b0, e_collide = 1'b0;
  logic [7:0]  e_data = '0;

  always @(posedge clk25 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      m_mode = 0; m_run = 0; m_t = 0;
      e_busy = 1'b0; e_valid = 1'b0; e_done = 1'b0;
      e_own = 1'b0; e_collide = 1'b0; e_data = '0;
    end else begin
      if (e_own && !mcu_ss) e_collide = 1'b1;
      e_valid = 1'b0;
      e_done  = 1'b0;
      case (m_mode)
        0: if (rd_req) begin
             m_mode = 1; m_run = 0; e_busy = 1'b1;
             m_len = int'(rd_len); m_seq = {8'h03, rd_addr};
           end
        1: begin
             m_run = mcu_ss ? m_run + 1 : 0;
             if (m_run == IDLE_GAP) begin
               m_mode = 2; m_t = 0; e_own = 1'b1;
             end
           end
        default: begin
          m_t++;
          if (m_t >= 80 && (m_t - 80) % 16 == 0 && (m_t - 80) / 16 <= m_len) begin
            e_valid = 1'b1;
            e_data  = flash_bytes[(m_t - 80) / 16];
          end
          if (m_t == 80 + 16 * m_len + CS_HIGH + 1) begin
            e_done = 1'b1; e_busy = 1'b0; e_own = 1'b0; m_mode = 0;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk25) begin
    if (chk_en) begin
      int lastv;
      lastv = 80 + 16 * m_len;
      check("rd_busy", 32'(rd_busy), 32'(e_busy));
      check("rd_valid", 32'(rd_valid), 32'(e_valid));
      check("rd_done", 32'(rd_done), 32'(e_done));
      check("mcu_collide", 32'(mcu_collide), 32'(e_collide));
      if (e_valid) check("rd_data", 32'(rd_data), 32'(e_data));
      if (!e_own) begin
        check("pass_cclk", 32'(fl_cclk), 32'(mcu_sclk));
        check("pass_cs_n", 32'(fl_cs_n), 32'(mcu_ss));
        check("pass_txd", 32'(fl_txd), 32'(mcu_txd));
        check("pass_oen", 32'(fl_oen), 32'(mcu_oen));
        check("pass_rxd", 32'(mcu_rxd), 32'(fl_rxd));
      end else begin
        check("fab_mcu_rxd", 32'(mcu_rxd), 32'hF);
        if (m_t < lastv) begin
          check("fab_cs_n", 32'(fl_cs_n), 32'd0);
          check("fab_cclk", 32'(fl_cclk), 32'(m_t % 2));
          check("fab_oen", 32'(fl_oen), 32'hE);
          check("fab_txd_hi", 32'(fl_txd[3:2]), 32'h3);
          check("fab_mosi", 32'(fl_txd[0]), (m_t < 64) ? 32'(m_seq[31 - m_t / 2]) : 32'd0);
        end else begin
          check("tail_cs_n", 32'(fl_cs_n), 32'd1);
          check("tail_cclk", 32'(fl_cclk), 32'd0);
          check("tail_oen", 32'(fl_oen), 32'hF);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk25);
    #2;
  endtask

  // Cycle 0 is the cycle rd_req is high; mcu_ss is low for cycles < lo
  // (except a 2-cycle high glitch at 10/11) and pulses low at coll, coll+1.
  task automatic run_read(input logic [23:0] a, input logic [7:0] l, input int lo,
                          input int coll, output int first_v, output int done_c,
                          output int nv);
    first_v = -1; done_c = -1; nv = 0;
    for (int c = 0; c < 6000 && done_c < 0; c++) begin
      rd_req  = (c == 0);
      rd_addr = a;
      rd_len  = l;
      mcu_ss  = !((c < lo && !(c == 10 || c == 11)) || (coll > 0 && (c == coll || c == coll + 1)));
      @(negedge clk25);
      if (rd_valid) begin
        nv++;
        if (first_v < 0) first_v = c;
      end
      if (rd_done) done_c = c;
      tick();
    end
    rd_req = 1'b0;
    mcu_ss = 1'b1;
    check("read_timeout", 32'(done_c >= 0), 32'd1);
  endtask

  initial begin
    int fv, dc, nv, nd;
    for (int i = 0; i < 256; i++) flash_bytes[i] = 8'h00;

    repeat (3) @(posedge clk25);
    #2;
    check("rst_busy", 32'(rd_busy), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_done", 32'(rd_done), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_collide", 32'(mcu_collide), 32'd0);
    chk_en = 1'b1;
    fpga_rst_n = 1'b1;
    repeat (2) tick();

    // pass-through
    pass_mode = 1'b1; tb_rxd_pass = 4'h5;
    mcu_sclk = 1'b1; mcu_ss = 1'b0; mcu_txd = 4'hA; mcu_oen = 4'h0;
    #1;
    check("pt_cclk", 32'(fl_cclk), 32'd1);
    check("pt_cs_n", 32'(fl_cs_n), 32'd0);
    check("pt_txd", 32'(fl_txd), 32'hA);
    check("pt_oen", 32'(fl_oen), 32'h0);
    check("pt_rxd", 32'(mcu_rxd), 32'h5);
    tick(); mcu_sclk = 1'b0;
    tick(); mcu_sclk = 1'b1; mcu_txd = 4'h3;
    tick(); mcu_sclk = 1'b0; mcu_ss = 1'b1; mcu_txd = 4'h0; mcu_oen = 4'hF; pass_mode = 1'b0;
    repeat (2) tick();

    // single-byte read
    flash_bytes[0] = 8'hC3;
    run_read(24'h012345, 8'd0, 0, 0, fv, dc, nv);
    check("single_first_valid", 32'(fv), 32'd85);
    check("single_done", 32'(dc), 32'd88);
    check("single_count", 32'(nv), 32'd1);
    check("single_cmd_addr", cap, 32'h03012345);
    repeat (2) tick();

    // gap wait with a short idle glitch
    flash_bytes[0] = 8'hAA; flash_bytes[1] = 8'h55;
    run_read(24'hFEDCBA, 8'd1, 20, 0, fv, dc, nv);
    check("gap_first_valid", 32'(fv), 32'd104);
    check("gap_count", 32'(nv), 32'd2);
    check("gap_collide", 32'(mcu_collide), 32'd0);
    repeat (2) tick();

    // 256-byte burst
    for (int i = 0; i < 256; i++) flash_bytes[i] = 8'(i);
    run_read(24'h000100, 8'd255, 0, 0, fv, dc, nv);
    check("burst_count", 32'(nv), 32'd256);
    check("burst_first_valid", 32'(fv), 32'd85);
    check("burst_done", 32'(dc), 32'd4168);
    repeat (2) tick();

    // collision during data phase
    flash_bytes[0] = 8'h5A; flash_bytes[1] = 8'hA5;
    flash_bytes[2] = 8'h3C; flash_bytes[3] = 8'hC3;
    run_read(24'h123456, 8'd3, 0, 100, fv, dc, nv);
    check("coll_flag", 32'(mcu_collide), 32'd1);
    check("coll_count", 32'(nv), 32'd4);
    check("coll_done", 32'(dc), 32'd136);
    repeat (3) tick();
    check("coll_sticky", 32'(mcu_collide), 32'd1);

    // reset mid-address
    for (int c = 0; c < 31; c++) begin
      rd_req = (c == 0); rd_addr = 24'h654321; rd_len = 8'd7;
      tick();
    end
    rd_req = 1'b0;
    #3;
    fpga_rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(rd_busy), 32'd0);
    check("midrst_cs_n", 32'(fl_cs_n), 32'(mcu_ss));
    check("midrst_rxd", 32'(mcu_rxd), 32'(fl_rxd));
    check("midrst_collide", 32'(mcu_collide), 32'd0);
    repeat (3) tick();
    fpga_rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk25);
      if (rd_done) nd++;
      tick();
    end
    check("midrst_no_done", 32'(nd), 32'd0);

    // read after reset
    flash_bytes[0] = 8'h96;
    run_read(24'hABCDEF, 8'd0, 0, 0, fv, dc, nv);
    check("post_first_valid", 32'(fv), 32'd85);
    check("post_count", 32'(nv), 32'd1);
    check("post_cmd_addr", cap, 32'h03ABCDEF);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
